// File: rtl/log_capture_ctrl.sv
// Capture sequencer for the BRAM logging datapath: run-edge detect, write enable/address
// generation with decimation, and full/status flags. Define LOG_CAPTURE_CIRCULAR_EN for circular capture.
module log_capture_ctrl #(
    parameter int NB_ADDR  = 13,
    parameter int NB_DECIM = 8
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_run,
    input  logic                i_stop,
    input  logic [NB_DECIM-1:0] i_decim,
    output logic                o_wr_enb,
    output logic [NB_ADDR-1:0]  o_wr_addr,
    output logic                o_clr,
    output logic                o_busy,
    output logic                o_full,
    output logic [NB_ADDR:0]    o_count,
    output logic                o_wrapped
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOG   = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

    localparam logic [NB_ADDR-1:0]  ADDR_ONE  = {{(NB_ADDR-1){1'b0}}, 1'b1};
    localparam logic [NB_ADDR:0]    COUNT_ONE = {{NB_ADDR{1'b0}}, 1'b1};
    localparam logic [NB_ADDR:0]    COUNT_MAX = {1'b1, {NB_ADDR{1'b0}}};
    localparam logic [NB_DECIM-1:0] DCNT_ONE  = {{(NB_DECIM-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_s;
    logic                run_d_r;
    logic [NB_ADDR-1:0]  addr_r;
    logic [NB_ADDR:0]    count_r;
    logic [NB_DECIM-1:0] dcnt_r;
    logic [NB_DECIM-1:0] decim_r;
    logic                wrapped_r;
    logic                run_rise_s;
    logic                wr_s;
    logic                last_s;

    assign run_rise_s = i_run & ~run_d_r;
    assign wr_s       = (state_r == ST_LOG) && (dcnt_r == {NB_DECIM{1'b0}});
    assign last_s     = (addr_r == {NB_ADDR{1'b1}});

    // State register
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a write at the last address takes priority over stop
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run_rise_s) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_s = ST_LOG;
            end
            ST_LOG: begin
`ifdef LOG_CAPTURE_CIRCULAR_EN
                if (i_stop) begin
                    state_s = ST_FULL;
                end else begin
                    state_s = ST_LOG;
                end
`else
                if (wr_s && last_s) begin
                    state_s = ST_FULL;
                end else if (i_stop) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LOG;
                end
`endif
            end
            ST_FULL: begin
                if (run_rise_s) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Address, word count, decimation counter and wrap flag
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            run_d_r   <= 1'b0;
            addr_r    <= {NB_ADDR{1'b0}};
            count_r   <= {(NB_ADDR+1){1'b0}};
            dcnt_r    <= {NB_DECIM{1'b0}};
            decim_r   <= {NB_DECIM{1'b0}};
            wrapped_r <= 1'b0;
        end else begin
            run_d_r <= i_run;
            case (state_r)
                ST_CLEAR: begin
                    addr_r    <= {NB_ADDR{1'b0}};
                    count_r   <= {(NB_ADDR+1){1'b0}};
                    dcnt_r    <= {NB_DECIM{1'b0}};
                    decim_r   <= i_decim;
                    wrapped_r <= 1'b0;
                end
                ST_LOG: begin
                    if (dcnt_r == decim_r) begin
                        dcnt_r <= {NB_DECIM{1'b0}};
                    end else begin
                        dcnt_r <= dcnt_r + DCNT_ONE;
                    end
                    if (wr_s) begin
                        // address rolls over to 0 after the last word; count sticks at depth
                        addr_r <= addr_r + ADDR_ONE;
                        if (count_r != COUNT_MAX) begin
                            count_r <= count_r + COUNT_ONE;
                        end
`ifdef LOG_CAPTURE_CIRCULAR_EN
                        if (last_s) begin
                            wrapped_r <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    addr_r <= addr_r;
                end
            endcase
        end
    end

    assign o_wr_enb  = wr_s;
    assign o_wr_addr = addr_r;
    assign o_clr     = (state_r == ST_CLEAR);
    assign o_busy    = (state_r == ST_CLEAR) || (state_r == ST_LOG);
    assign o_full    = (state_r == ST_FULL);
    assign o_count   = count_r;
`ifdef LOG_CAPTURE_CIRCULAR_EN
    assign o_wrapped = wrapped_r;
`else
    assign o_wrapped = 1'b0;
`endif

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Self-checking bench for log_capture_ctrl: capture-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized run/stop/decim/reset.
module tb_log_capture_ctrl;

    localparam int NA    = 4;
    localparam int ND    = 4;
    localparam int DEPTH = 1 << NA;

    logic          clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_run = 1'b0;
    logic          i_stop = 1'b0;
    logic [ND-1:0] i_decim = '0;
    logic          o_wr_enb;
    logic [NA-1:0] o_wr_addr;
    logic          o_clr;
    logic          o_busy;
    logic          o_full;
    logic [NA:0]   o_count;
    logic          o_wrapped;

    int vectors = 0;
    int miscompares = 0;

    log_capture_ctrl #(.NB_ADDR(NA), .NB_DECIM(ND)) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_run     (i_run),
        .i_stop    (i_stop),
        .i_decim   (i_decim),
        .o_wr_enb  (o_wr_enb),
        .o_wr_addr (o_wr_addr),
        .o_clr     (o_clr),
        .o_busy    (o_busy),
        .o_full    (o_full),
        .o_count   (o_count),
        .o_wrapped (o_wrapped)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Reference model: a capture phase plus "cycles spent logging" (k) and "words written" (nw);
    // everything visible is derived arithmetically from those.
    localparam int P_IDLE = 0, P_CLEAR = 1, P_LOG = 2, P_FULL = 3;
    int m_phase = P_IDLE;
    int m_run_d = 0;
    int m_k = 0;
    int m_d = 0;
    int m_nw = 0;

    initial begin
        int exp_wr, exp_cnt, exp_wrap, rise, wrote;
        forever begin
            @(negedge clock);
            if (i_reset) begin
                m_phase = P_IDLE; m_run_d = 0; m_k = 0; m_d = 0; m_nw = 0;
            end
            exp_wr  = (m_phase == P_LOG && (m_k % (m_d + 1)) == 0) ? 1 : 0;
            exp_cnt = (m_nw > DEPTH) ? DEPTH : m_nw;
`ifdef LOG_CAPTURE_CIRCULAR_EN
            exp_wrap = (m_nw >= DEPTH) ? 1 : 0;
`else
            exp_wrap = 0;
`endif
            check("m_wr_enb",  32'(o_wr_enb),  32'(exp_wr));
            check("m_wr_addr", 32'(o_wr_addr), 32'(m_nw % DEPTH));
            check("m_clr",     32'(o_clr),     32'(m_phase == P_CLEAR));
            check("m_busy",    32'(o_busy),    32'(m_phase == P_CLEAR || m_phase == P_LOG));
            check("m_full",    32'(o_full),    32'(m_phase == P_FULL));
            check("m_count",   32'(o_count),   32'(exp_cnt));
            check("m_wrapped", 32'(o_wrapped), 32'(exp_wrap));
            if (!i_reset) begin
                rise = (i_run && m_run_d == 0) ? 1 : 0;
                m_run_d = i_run ? 1 : 0;
                case (m_phase)
                    P_IDLE:  if (rise != 0) m_phase = P_CLEAR;
                    P_CLEAR: begin m_phase = P_LOG; m_k = 0; m_nw = 0; m_d = int'(i_decim); end
                    P_LOG: begin
                        wrote = ((m_k % (m_d + 1)) == 0) ? 1 : 0;
                        m_nw = m_nw + wrote;
                        m_k++;
`ifdef LOG_CAPTURE_CIRCULAR_EN
                        if (i_stop) m_phase = P_FULL;
`else
                        if (wrote != 0 && m_nw == DEPTH) m_phase = P_FULL;
                        else if (i_stop) m_phase = P_IDLE;
`endif
                    end
                    P_FULL:  if (rise != 0) m_phase = P_CLEAR;
                    default: m_phase = P_IDLE;
                endcase
            end
        end
    end

    initial begin
        repeat (2) cyc();
        i_reset = 1'b0;
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_count", 32'(o_count), 32'd0);
        repeat (3) cyc();
        i_run = 1'b1;
        cyc();
        check("start_clr", 32'(o_clr), 32'd1);
        i_run = 1'b0;
`ifdef LOG_CAPTURE_CIRCULAR_EN
        for (int j = 0; j < 20; j++) begin
            cyc();
            check("circ_wr", 32'(o_wr_enb), 32'd1);
            check("circ_addr", 32'(o_wr_addr), 32'(j % DEPTH));
        end
        i_stop = 1'b1;
        cyc();
        i_stop = 1'b0;
        check("circ_wrapped", 32'(o_wrapped), 32'd1);
        check("circ_full", 32'(o_full), 32'd1);
        check("circ_count", 32'(o_count), 32'd16);
        check("circ_addr_end", 32'(o_wr_addr), 32'd4);
`else
        for (int j = 0; j < 16; j++) begin
            cyc();
            check("fill_wr", 32'(o_wr_enb), 32'd1);
            check("fill_addr", 32'(o_wr_addr), 32'(j));
        end
        cyc();
        check("fill_full", 32'(o_full), 32'd1);
        check("fill_count", 32'(o_count), 32'd16);
        repeat (3) begin
            cyc();
            check("full_no_write", 32'(o_wr_enb), 32'd0);
        end
        // decimation by 3; i_decim change during LOG must be ignored
        i_decim = 4'd2; i_run = 1'b1;
        cyc();
        check("decim_clr", 32'(o_clr), 32'd1);
        i_run = 1'b0;
        for (int j = 0; j < 9; j++) begin
            cyc();
            i_decim = 4'd0;
            check("decim_wr", 32'(o_wr_enb), 32'((j % 3) == 0));
            if ((j % 3) == 0) check("decim_addr", 32'(o_wr_addr), 32'(j / 3));
        end
        i_stop = 1'b1;
        cyc();
        i_stop = 1'b0;
        check("decim_stop_count", 32'(o_count), 32'd3);
        // stop after five writes
        i_run = 1'b1;
        cyc();
        i_run = 1'b0;
        repeat (5) cyc();
        i_stop = 1'b1;
        cyc();
        i_stop = 1'b0;
        check("stop_busy", 32'(o_busy), 32'd0);
        check("stop_full", 32'(o_full), 32'd0);
        check("stop_count", 32'(o_count), 32'd5);
        i_run = 1'b1;
        cyc();
        check("restart_clr", 32'(o_clr), 32'd1);
        i_run = 1'b0;
        cyc();
        check("restart_count", 32'(o_count), 32'd0);
        repeat (16) cyc();
        check("restart_full", 32'(o_full), 32'd1);
        // i_run held high gives one capture only
        i_run = 1'b1;
        cyc();
        repeat (17) cyc();
        check("hold_full", 32'(o_full), 32'd1);
        repeat (4) begin
            cyc();
            check("hold_no_clr", 32'(o_clr), 32'd0);
        end
        i_run = 1'b0;
        cyc();
        i_run = 1'b1;
        cyc();
        check("rearm_clr", 32'(o_clr), 32'd1);
        check("rearm_full", 32'(o_full), 32'd0);
        repeat (3) cyc();
        // asynchronous reset mid-LOG, i_run still high at release
        #2 i_reset = 1'b1;
        #1;
        check("async_busy", 32'(o_busy), 32'd0);
        check("async_wr", 32'(o_wr_enb), 32'd0);
        check("async_count", 32'(o_count), 32'd0);
        check("async_addr", 32'(o_wr_addr), 32'd0);
        cyc();
        i_reset = 1'b0;
        cyc();
        check("release_clr", 32'(o_clr), 32'd1);
        i_run = 1'b0;
`endif
        for (int c = 0; c < 800; c++) begin
            cyc();
            if ($urandom_range(0, 9) == 0) i_run = ~i_run;
            i_stop = ($urandom_range(0, 39) == 0);
            i_decim = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                #2 i_reset = 1'b1;
                cyc();
                i_reset = 1'b0;
            end
        end
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/log_capture_ctrl.md
Name: log_capture_ctrl

Overview:
- Sequencer for the BRAM logging datapath.
- Detects the micro's run request and clears the write address.
- Generates the BRAM write enable and write address, with optional decimation.
- Raises a memory-full flag for the micro and exposes capture status.
- Sits between the micro register file and the BRAM write port; the data source (step counter) is outside this block.

Parameters:
- NB_ADDR, 13, BRAM address width; depth = 2^NB_ADDR words.
- NB_DECIM, 8, width of the decimation ratio input.

Ports:
- clock  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_run  input  1  level from micro; a rising edge starts a capture.
- i_stop  input  1  level; aborts (or, with the option, ends) an active capture.
- i_decim  input  NB_DECIM  write one sample every i_decim+1 cycles; latched in CLEAR.
- o_wr_enb  output  1  BRAM write enable.
- o_wr_addr  output  NB_ADDR  BRAM write address.
- o_clr  output  1  one-cycle pulse at capture start; resets the external data source.
- o_busy  output  1  high in CLEAR and LOG.
- o_full  output  1  memory full / capture complete.
- o_count  output  NB_ADDR+1  words written since the last CLEAR.
- o_wrapped  output  1  circular-mode wrap flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, run_d=0, addr=0, dcnt=0, count=0, decim_q=0, all outputs 0.
- Rising-edge detect: run_rise = i_run & ~run_d; run_d registers i_run every cycle. Because run_d resets to 0, i_run already high when reset deasserts counts as a rising edge.
- States and transitions:
  - IDLE: run_rise -> CLEAR.
  - CLEAR (1 cycle): o_clr=1, addr<=0, count<=0, dcnt<=0, decim_q<=i_decim, o_full<=0 -> LOG.
  - LOG: o_wr_enb = (dcnt==0), combinational from registers.
    - On a write: addr<=addr+1, count<=count+1.
    - dcnt counts 0..decim_q, then wraps to 0.
    - Write at addr==2^NB_ADDR-1 -> FULL; o_full=1 from the next cycle.
    - Otherwise i_stop=1 -> IDLE, keeping count and addr.
  - FULL: o_full=1, no writes. run_rise -> CLEAR (re-arm); i_stop ignored.
- Timing: the first write occurs in the cycle after CLEAR, i.e. 2 cycles after the rising edge of i_run is sampled. With i_decim=0, one write per cycle.
- Simultaneous i_stop and final-address write: the write completes and FULL wins.
- run_rise while in CLEAR or LOG: ignored, no restart.
- i_decim changes during LOG: ignored until the next CLEAR.
- o_count saturates naturally at 2^NB_ADDR, which is why it is NB_ADDR+1 bits wide.
- Reset mid-capture: immediate return to IDLE; the BRAM contents are not touched.
- o_busy = (state==CLEAR)|(state==LOG).

Optional Feature:
- Macro: LOG_CAPTURE_CIRCULAR_EN.
- Defined:
  - In LOG, a write at the last address wraps addr to 0 instead of going to FULL.
  - o_wrapped is set (sticky until CLEAR) and count stays at 2^NB_ADDR.
  - Capture ends only on i_stop -> FULL with o_full=1; o_wr_addr holds the next address, i.e. the oldest sample.
- Undefined: behaviour as above; o_wrapped tied to 0.

Test Plan (NB_ADDR=4, NB_DECIM=4):
- Reset with i_run=0; pulse i_run high at cycle 5 -> o_clr=1 at cycle 6; o_wr_enb=1 with addr 0..15 on cycles 7..22; o_full=1 and o_count=16 at cycle 23; no further writes.
- i_decim=2, start capture -> o_wr_enb on every third cycle; addresses 0,1,2 written at cycles +0,+3,+6 after CLEAR.
- Assert i_stop after 5 writes -> state IDLE, o_full=0, o_count=5; a new i_run edge -> o_clr pulse, o_count back to 0.
- Hold i_run high, toggle nothing -> only one capture; drop then raise i_run while in FULL -> new capture, o_full clears in CLEAR.
- Assert i_reset asynchronously mid-LOG (between clock edges) -> all outputs 0 immediately; i_run high at release -> new capture starts.
- With LOG_CAPTURE_CIRCULAR_EN: 20 writes, then i_stop -> o_wrapped=1, o_full=1, o_count=16, o_wr_addr=4.
